// File: rtl/hazard_pkg.sv
// Shared encodings and widths for the pipeline hazard controller.
// Forward selects, multi-cycle FSM states and the iteration counter width.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {S_IDLE, S_BUSY} mulState_t;

    localparam int MUL_CNT_W = $clog2(16);

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle; slave is the controller side.
// All controls are level signals sampled every cycle, no handshake.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic             MulBusy, MulDone;
    logic [CNT_W-1:0] StallCount;

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, MulBusy, MulDone, StallCount
    );

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, MulBusy, MulDone, StallCount
    );
endinterface

// File: rtl/hazard_controller_fwd_sel.sv
// Operand forward select for one execute-stage source register.
// Purely combinational; the M stage result wins over W, x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] Forward
);
    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE))
            Forward = FWD_MEM;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE))
            Forward = FWD_WB;
    end
endmodule

// File: rtl/hazard_controller.sv
// Forwarding, load-use/multi-cycle stalls, branch flushes and stall-cycle counter.
// Controls are combinational (zero latency); a multi-cycle op holds E and overrides flushes of D/E.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rst,
    hazard_controller_if.slave hz
);
    localparam int                   LOAD_I   = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(LOAD_I);

    mulState_t            state, stateNext;
    logic [MUL_CNT_W-1:0] cnt, cntNext;
    logic                 mulBusy, mulDone, mulHold, lwStall, stallF;
    logic [1:0]           fwdA, fwdB;
    logic [CNT_W-1:0]     stallCount;

    fwd_sel uFwdA (.RsE(hz.Rs1E), .RdM(hz.RdM), .RdW(hz.RdW),
                   .RegWriteM(hz.RegWriteM), .RegWriteW(hz.RegWriteW), .Forward(fwdA));
    fwd_sel uFwdB (.RsE(hz.Rs2E), .RdM(hz.RdM), .RdW(hz.RdW),
                   .RegWriteM(hz.RegWriteM), .RegWriteW(hz.RegWriteW), .Forward(fwdB));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mulBusy   = 1'b0;
        mulDone   = 1'b0;
        case (state)
            S_IDLE: begin
                if (hz.MulStartE) begin
                    mulBusy = 1'b1;
                    if (MUL_CYCLES > 1) begin
                        stateNext = S_BUSY;
                        cntNext   = MUL_LOAD;
                    end else begin
                        mulDone = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                mulBusy = 1'b1;
                if (cnt == '0) begin
                    mulDone   = 1'b1;
                    stateNext = S_IDLE;
                end else begin
                    cntNext = cnt - MUL_CNT_W'(1);
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    assign mulHold = mulBusy && !mulDone;
    assign lwStall = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Controls are masked while reset is held so a lingering MulStartE cannot look like a new op.
    assign stallF        = rst && (mulHold || lwStall);
    assign hz.StallF     = stallF;
    assign hz.StallD     = stallF;
    assign hz.StallE     = rst && mulHold;
    assign hz.FlushM     = rst && mulHold;
    assign hz.FlushD     = rst && !mulHold && hz.PCSrcE;
    assign hz.FlushE     = rst && !mulHold && (hz.PCSrcE || lwStall);
    assign hz.MulBusy    = rst && mulBusy;
    assign hz.MulDone    = rst && mulDone;
    assign hz.ForwardAE  = fwdA;
    assign hz.ForwardBE  = fwdB;
    assign hz.StallCount = stallCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stallCount <= '0;
        else if (stallF && (stallCount != '1))
            stallCount <= stallCount + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench: driver queues expected outputs, negedge monitor compares.
// Covers forwarding priority, load-use, branch, multi-cycle hold/override, reset abort, MUL_CYCLES=1.
module tb_hazard_controller;

    typedef struct {
        int          dut;
        string       name;
        logic [11:0] flags;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   total;
    int   bad;

    hazard_controller_if #(.CNT_W(32)) bus4 ();
    hazard_controller_if #(.CNT_W(32)) bus1 ();

    hazard_controller #(.MUL_CYCLES(4), .CNT_W(32)) dut4 (.clk(clk), .rst(rst), .hz(bus4));
    hazard_controller #(.MUL_CYCLES(1), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .hz(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // f = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDone}
    task automatic chk(input int d, input string nm, input logic [1:0] a, input logic [1:0] b,
                       input logic [7:0] f, input logic [31:0] c);
        exp_t e;
        e.dut   = d;
        e.name  = nm;
        e.flags = {a, b, f};
        e.cnt   = c;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        bus4.Rs1D = 0; bus4.Rs2D = 0; bus4.Rs1E = 0; bus4.Rs2E = 0;
        bus4.RdE = 0; bus4.RdM = 0; bus4.RdW = 0;
        bus4.RegWriteM = 0; bus4.RegWriteW = 0; bus4.ResultSrcE = 0;
        bus4.PCSrcE = 0; bus4.MulStartE = 0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [11:0] gf;
            logic [31:0] gc;
            e = q.pop_front();
            if (e.dut == 1) begin
                gf = {bus1.ForwardAE, bus1.ForwardBE, bus1.StallF, bus1.StallD, bus1.StallE,
                      bus1.FlushD, bus1.FlushE, bus1.FlushM, bus1.MulBusy, bus1.MulDone};
                gc = bus1.StallCount;
            end else begin
                gf = {bus4.ForwardAE, bus4.ForwardBE, bus4.StallF, bus4.StallD, bus4.StallE,
                      bus4.FlushD, bus4.FlushE, bus4.FlushM, bus4.MulBusy, bus4.MulDone};
                gc = bus4.StallCount;
            end
            total++;
            if (gf !== e.flags || gc !== e.cnt) begin
                bad++;
                $display("FAIL %s (dut%0d): got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                         e.name, e.dut, gf, gc, e.flags, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clearIn();
        bus1.Rs1D = 0; bus1.Rs2D = 0; bus1.Rs1E = 0; bus1.Rs2E = 0;
        bus1.RdE = 0; bus1.RdM = 0; bus1.RdW = 0;
        bus1.RegWriteM = 0; bus1.RegWriteW = 0; bus1.ResultSrcE = 0;
        bus1.PCSrcE = 0; bus1.MulStartE = 0;

        step();
        chk(4, "reset4", 2'b00, 2'b00, 8'b00000000, 0);
        chk(1, "reset1", 2'b00, 2'b00, 8'b00000000, 0);

        step(); rst = 1'b1;
        chk(4, "idle4", 2'b00, 2'b00, 8'b00000000, 0);
        chk(1, "idle1", 2'b00, 2'b00, 8'b00000000, 0);

        // Forwarding; dut1 exercises single-cycle ops in parallel
        step(); bus4.RdM = 5; bus4.RegWriteM = 1; bus4.Rs1E = 5; bus1.MulStartE = 1;
        chk(4, "fwdM", 2'b10, 2'b00, 8'b00000000, 0);
        chk(1, "mul1done", 2'b00, 2'b00, 8'b00000011, 0);

        step(); bus4.RdW = 5; bus4.RegWriteW = 1; bus1.MulStartE = 0;
        chk(4, "fwdMoverW", 2'b10, 2'b00, 8'b00000000, 0);
        chk(1, "mul1idle", 2'b00, 2'b00, 8'b00000000, 0);

        step(); bus4.RegWriteM = 0; bus1.MulStartE = 1;
        chk(4, "fwdW", 2'b01, 2'b00, 8'b00000000, 0);
        chk(1, "mul1again", 2'b00, 2'b00, 8'b00000011, 0);

        step(); bus4.RdM = 0; bus4.RdW = 0; bus4.RegWriteM = 1; bus4.Rs1E = 0; bus1.MulStartE = 0;
        chk(4, "fwdX0", 2'b00, 2'b00, 8'b00000000, 0);
        chk(1, "mul1end", 2'b00, 2'b00, 8'b00000000, 0);

        step(); bus4.RdM = 3; bus4.Rs1E = 3; bus4.RdW = 9; bus4.RegWriteW = 1; bus4.Rs2E = 9;
        chk(4, "fwdBothOps", 2'b10, 2'b01, 8'b00000000, 0);

        step(); bus4.RegWriteM = 0; bus4.RegWriteW = 0;
        chk(4, "fwdNoWrite", 2'b00, 2'b00, 8'b00000000, 0);

        // Load-use and branch
        step(); clearIn(); bus4.ResultSrcE = 1; bus4.RdE = 7; bus4.Rs2D = 7;
        chk(4, "loadUse", 2'b00, 2'b00, 8'b11001000, 0);

        step(); clearIn();
        chk(4, "afterLoad", 2'b00, 2'b00, 8'b00000000, 1);

        step(); bus4.ResultSrcE = 1; bus4.RdE = 0; bus4.Rs1D = 0;
        chk(4, "loadRdX0", 2'b00, 2'b00, 8'b00000000, 1);

        step(); clearIn(); bus4.PCSrcE = 1;
        chk(4, "branch", 2'b00, 2'b00, 8'b00011000, 1);

        step(); bus4.ResultSrcE = 1; bus4.RdE = 4; bus4.Rs1D = 4;
        chk(4, "branchLoad", 2'b00, 2'b00, 8'b11011000, 1);

        // Four-cycle op with concurrent load-use and branch attempts
        step(); clearIn(); bus4.MulStartE = 1; bus4.ResultSrcE = 1; bus4.RdE = 7; bus4.Rs1D = 7;
        chk(4, "mulC0", 2'b00, 2'b00, 8'b11100110, 2);

        step(); bus4.PCSrcE = 1;
        chk(4, "mulC1br", 2'b00, 2'b00, 8'b11100110, 3);

        step(); bus4.PCSrcE = 0;
        chk(4, "mulC2", 2'b00, 2'b00, 8'b11100110, 4);

        step(); bus4.ResultSrcE = 0; bus4.RdE = 0; bus4.Rs1D = 0; bus4.PCSrcE = 1;
        chk(4, "mulFinalBr", 2'b00, 2'b00, 8'b00011011, 5);

        step(); bus4.PCSrcE = 0;
        chk(4, "mulRestart", 2'b00, 2'b00, 8'b11100110, 5);

        // Reset in the second cycle of the op
        step(); rst = 1'b0;
        chk(4, "rstMidOp", 2'b00, 2'b00, 8'b00000000, 0);

        step(); rst = 1'b1; bus4.MulStartE = 0;
        chk(4, "afterRst", 2'b00, 2'b00, 8'b00000000, 0);

        step(); bus4.MulStartE = 1;
        chk(4, "freshStart", 2'b00, 2'b00, 8'b11100110, 0);

        step();
        chk(4, "freshHold", 2'b00, 2'b00, 8'b11100110, 1);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It drives the execute stage's operand-forwarding selects and issues stall and flush controls to the F/D/E/M pipeline registers. Stalls cover load-use hazards and multi-cycle execute operations (iterative multiply); flushes cover taken branches. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MUL_CYCLES, 4, number of cycles a multi-cycle op occupies the execute stage (legal range 1..16).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- Rs1D, Rs2D  in  5 each  source register indices of the instruction in Decode.
- Rs1E, Rs2E  in  5 each  source register indices of the instruction in Execute.
- RdE, RdM, RdW  in  5 each  destination register index in E, M and W.
- RegWriteM, RegWriteW  in  1 each  destination-write enables in M and W.
- ResultSrcE  in  1  the instruction in E is a load.
- PCSrcE  in  1  branch taken, resolved in E.
- MulStartE  in  1  the instruction in E is a multi-cycle op.
- ForwardAE, ForwardBE  out  2 each  operand-forwarding selects.
- StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers.
- FlushD, FlushE, FlushM  out  1 each  insert a bubble into IF/ID, ID/EX and EX/MEM.
- MulBusy  out  1  a multi-cycle op is in progress.
- MulDone  out  1  pulse in the final execute cycle of a multi-cycle op.
- StallCount  out  CNT_W  total number of stall cycles.

## Operation
Forwarding (combinational, per operand X in {1,2}):
- 2'b10 (EX/MEM ALU result) when RegWriteM, RdM != 0 and RdM == RsXE.
- Otherwise 2'b01 (ResultW) when RegWriteW, RdW != 0 and RdW == RsXE.
- Otherwise 2'b00 (register file).
- M has priority over W. x0 is never forwarded.

Load-use hazard (lwStall):
- Asserted when ResultSrcE is set, RdE != 0, and RdE equals Rs1D or Rs2D.
- Effect: StallF = StallD = 1 and FlushE = 1, for one cycle.

Branch:
- When PCSrcE is set, FlushD = FlushE = 1.

Multi-cycle FSM states:
- IDLE: when MulStartE is set and MUL_CYCLES > 1, load cnt = MUL_CYCLES-2 and go to BUSY; MulBusy = 1 in this cycle.
- BUSY: if cnt == 0, go to IDLE; else cnt decrements.
- mulHold = MulBusy and the current cycle is not the final one.

Outputs while mulHold:
- StallF = StallD = StallE = 1 and FlushM = 1.
- FlushE and FlushD are forced to 0, so the held E instruction is kept. This overrides both lwStall and branch flushes.
- MulDone = 1 in the final cycle: BUSY with cnt == 0, or IDLE with MulStartE when MUL_CYCLES == 1.

Other rules:
- PCSrcE is ignored while mulHold (a multi-cycle op is never a branch).
- In the final mul cycle, lwStall and PCSrcE apply normally.
- StallCount increments once in any cycle where StallF = 1, and saturates at all-ones.

## Timing
- Reset (rst low, asynchronous): FSM to IDLE, cnt = 0, StallCount = 0.
  - All stall and flush outputs are 0, as are MulBusy and MulDone.
  - ForwardAE and ForwardBE are 2'b00 whenever inputs imply no match.
- Reset mid-operation aborts the op. The first cycle after release is IDLE.
- Forward, stall and flush outputs are combinational from the current inputs and state, with zero-cycle latency.
- A multi-cycle op raised at cycle t holds E during cycles t..t+MUL_CYCLES-2 and completes at t+MUL_CYCLES-1.
- MulStartE must stay high while held; the bench drives it that way.
- MulStartE high in BUSY is not a new start. A new op can start in the cycle after MulDone.
- StallCount updates on the clock edge following a stalled cycle.

## Structure
- hazard_pkg holds:
  - forward encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the state enum {S_IDLE, S_BUSY};
  - the counter width localparam, $clog2(16).
- Sub-module fwd_sel computes one 2-bit select from RsE, RdM, RdW, RegWriteM and RegWriteW. It is instantiated twice.
- The FSM, lwStall logic and perf counter live in the top module.

## Test plan
- RAW from M: RdM = 5, RegWriteM = 1, Rs1E = 5 -> ForwardAE = 2'b10. With RdW = 5 also set, the result is still 2'b10. With RdM = 0, Rs1E = 0 -> 2'b00.
- Load-use: ResultSrcE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly one cycle; StallCount goes 0 -> 1.
- Branch: PCSrcE = 1 with no other hazard -> FlushD = FlushE = 1 and StallF = 0.
- Multiply, MUL_CYCLES = 4, MulStartE at cycle 10:
  - StallE = FlushM = 1 in cycles 10..12; MulDone only in cycle 13; MulBusy in 10..13; StallCount = 3.
  - A concurrent lwStall condition does not raise FlushE during 10..12.
- Reset at cycle 11 of the above op -> all outputs 0 immediately; IDLE after release; StallCount = 0.
- MUL_CYCLES = 1 -> MulStartE yields MulDone for one cycle, no stall, MulBusy = 1 in that cycle.
